// File: rtl/tlb_l2_pkg.sv
// Shared types and constants for the L2 TLB port arbiter.
package tlb_l2_pkg;

    // Cycles the L2 is busy after reset or flush-all: start + 256-set sweep + return.
    localparam int unsigned FLUSH_CYCLES = 258;
    localparam logic [8:0]  FLUSH_LOAD   = 9'(FLUSH_CYCLES - 1);

    // The L2 only stores fills whose physical address is below 64 MB.
    localparam logic [31:0] PHYS_LIMIT = 32'h0400_0000;

    typedef enum logic [2:0] {
        StWaitFlush,
        StIdle,
        StLkAddr,
        StLkCmp,
        StWrite,
        StFlush1,
        StFlall
    } state_e;

    typedef struct packed {
        logic        hit;
        logic [31:0] physical;
        logic        pwt;
        logic        pcd;
        logic        crw;
        logic        csu;
    } lookup_res_t;

    // True when the L2 will keep a fill with this physical address.
    function automatic logic phys_accepted(logic [31:0] physical);
        return physical < PHYS_LIMIT;
    endfunction

endpackage

// File: rtl/tlb_l2_lookup_pick.sv
// Grant selection between the code and data lookup requesters.
// TLB_L2_ARB_RR_EN: round-robin between the two; otherwise data always wins.
module tlb_l2_lookup_pick (
`ifdef TLB_L2_ARB_RR_EN
    input  logic clk,
    input  logic rst,
    input  logic take,
`endif
    input  logic code_do,
    input  logic data_do,
    output logic grant_valid,
    output logic grant_data
);

`ifdef TLB_L2_ARB_RR_EN
    // 1 = data has priority on the next contested grant.
    logic ptr_data_q;

    // Pick the requester; the pointer breaks ties.
    always_comb begin
        grant_valid = code_do | data_do;
        grant_data  = data_do;
        if (code_do && data_do) begin
            grant_data = ptr_data_q;
        end
    end

    // After a grant, favour the source that was not served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_data_q <= 1'b0;
        end else if (take) begin
            ptr_data_q <= ~grant_data;
        end
    end
`else
    // Fixed priority: data beats code.
    always_comb begin
        grant_valid = code_do | data_do;
        grant_data  = data_do;
    end
`endif

endmodule

// File: rtl/tlb_l2_arbiter.sv
// Sequencer sharing the single L2 TLB port between lookups, fills and invalidations.
// Optional macro TLB_L2_ARB_RR_EN selects round-robin code/data lookup arbitration.
module tlb_l2_arbiter
    import tlb_l2_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        code_req_do,
    input  logic [31:0] code_req_linear,
    input  logic        code_req_rw,
    output logic        code_done,
    output logic        code_hit,
    output logic [31:0] code_physical,
    output logic        code_pwt,
    output logic        code_pcd,
    output logic        code_crw,
    output logic        code_csu,

    input  logic        data_req_do,
    input  logic [31:0] data_req_linear,
    input  logic        data_req_rw,
    output logic        data_done,
    output logic        data_hit,
    output logic [31:0] data_physical,
    output logic        data_pwt,
    output logic        data_pcd,
    output logic        data_crw,
    output logic        data_csu,

    input  logic        wr_do,
    input  logic [31:0] wr_linear,
    input  logic [31:0] wr_physical,
    input  logic        wr_pwt,
    input  logic        wr_pcd,
    input  logic        wr_crw,
    input  logic        wr_csu,
    input  logic        wr_dirty,
    output logic        wr_done,

    input  logic        fl1_do,
    input  logic [31:0] fl1_address,
    output logic        fl1_done,

    input  logic        flall_do,
    output logic        flall_done,

    output logic        l2_translate_do,
    output logic [31:0] l2_translate_linear,
    output logic        l2_rw,
    output logic        l2_write_do,
    output logic [31:0] l2_write_linear,
    output logic [31:0] l2_write_physical,
    output logic        l2_write_pwt,
    output logic        l2_write_pcd,
    output logic        l2_write_crw,
    output logic        l2_write_csu,
    output logic        l2_flushsingle_do,
    output logic [31:0] l2_flushsingle_address,
    output logic        l2_flushall_do,

    input  logic        l2_translate_valid,
    input  logic [31:0] l2_translate_physical,
    input  logic        l2_translate_pwt,
    input  logic        l2_translate_pcd,
    input  logic        l2_translate_crw,
    input  logic        l2_translate_csu
);

    state_e      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        grant_valid, grant_data;
    logic        take_lk, ld_wr, ld_fl1;
    logic        src_data_q, rw_q;
    logic [31:0] lk_linear_q, wr_linear_q, wr_physical_q, fl1_address_q;
    logic [3:0]  wr_attr_q;
    lookup_res_t code_res_q, data_res_q, l2_res;

    tlb_l2_lookup_pick u_pick (
`ifdef TLB_L2_ARB_RR_EN
        .clk         (clk),
        .rst         (rst),
        .take        (take_lk),
`endif
        .code_do     (code_req_do),
        .data_do     (data_req_do),
        .grant_valid (grant_valid),
        .grant_data  (grant_data)
    );

    assign l2_res = {l2_translate_valid, l2_translate_physical, l2_translate_pwt,
                     l2_translate_pcd, l2_translate_crw, l2_translate_csu};

    // Next-state: fixed priority in IDLE, every operation returns through IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take_lk = 1'b0;
        ld_wr   = 1'b0;
        ld_fl1  = 1'b0;
        unique case (state_q)
            StWaitFlush, StFlall: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            StIdle: begin
                if (flall_do) begin
                    state_d = StFlall;
                    cnt_d   = FLUSH_LOAD;
                end else if (fl1_do) begin
                    state_d = StFlush1;
                    ld_fl1  = 1'b1;
                end else if (wr_do) begin
                    state_d = StWrite;
                    ld_wr   = 1'b1;
                end else if (grant_valid) begin
                    state_d = StLkAddr;
                    take_lk = 1'b1;
                end
            end
            StLkAddr: state_d = StLkCmp;
            // LK_CMP, WRITE and FLUSH1 always hand back to IDLE.
            default:  state_d = StIdle;
        endcase
    end

    // L2 strobes decode straight from state; flush-all only on its first cycle.
    always_comb begin
        l2_translate_do   = (state_q == StLkAddr) || (state_q == StLkCmp);
        l2_write_do       = (state_q == StWrite);
        l2_flushsingle_do = (state_q == StFlush1);
        l2_flushall_do    = (state_q == StFlall) && (cnt_q == FLUSH_LOAD);
    end

    // State and sweep counter; reset starts in the L2's own reset sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StWaitFlush;
            cnt_q   <= FLUSH_LOAD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Done pulses land in the IDLE cycle that follows each operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_done  <= 1'b0;
            data_done  <= 1'b0;
            wr_done    <= 1'b0;
            fl1_done   <= 1'b0;
            flall_done <= 1'b0;
        end else begin
            code_done  <= (state_q == StLkCmp) && !src_data_q;
            data_done  <= (state_q == StLkCmp) && src_data_q;
            wr_done    <= (state_q == StWrite);
            fl1_done   <= (state_q == StFlush1);
            flall_done <= (state_q == StFlall) && (cnt_q == '0);
        end
    end

    // Latch the granted request; these also hold the L2 buses between operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_data_q    <= 1'b0;
            rw_q          <= 1'b0;
            lk_linear_q   <= '0;
            wr_linear_q   <= '0;
            wr_physical_q <= '0;
            wr_attr_q     <= '0;
            fl1_address_q <= '0;
        end else begin
            if (take_lk) begin
                src_data_q  <= grant_data;
                lk_linear_q <= grant_data ? data_req_linear : code_req_linear;
                rw_q        <= grant_data ? data_req_rw : code_req_rw;
            end
            if (ld_wr) begin
                wr_linear_q   <= wr_linear;
                wr_physical_q <= wr_physical;
                wr_attr_q     <= {wr_pwt, wr_pcd, wr_crw, wr_csu};
                rw_q          <= wr_dirty;
            end
            if (ld_fl1) begin
                fl1_address_q <= fl1_address;
            end
        end
    end

    // Capture the L2 read result for whichever source owns the lookup.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_res_q <= '0;
            data_res_q <= '0;
        end else if (state_q == StLkCmp) begin
            if (src_data_q) begin
                data_res_q <= l2_res;
            end else begin
                code_res_q <= l2_res;
            end
        end
    end

    assign l2_translate_linear    = lk_linear_q;
    assign l2_rw                  = rw_q;
    assign l2_write_linear        = wr_linear_q;
    assign l2_write_physical      = wr_physical_q;
    assign l2_write_pwt           = wr_attr_q[3];
    assign l2_write_pcd           = wr_attr_q[2];
    assign l2_write_crw           = wr_attr_q[1];
    assign l2_write_csu           = wr_attr_q[0];
    assign l2_flushsingle_address = fl1_address_q;

    assign code_hit      = code_res_q.hit;
    assign code_physical = code_res_q.physical;
    assign code_pwt      = code_res_q.pwt;
    assign code_pcd      = code_res_q.pcd;
    assign code_crw      = code_res_q.crw;
    assign code_csu      = code_res_q.csu;
    assign data_hit      = data_res_q.hit;
    assign data_physical = data_res_q.physical;
    assign data_pwt      = data_res_q.pwt;
    assign data_pcd      = data_res_q.pcd;
    assign data_crw      = data_res_q.crw;
    assign data_csu      = data_res_q.csu;

endmodule

// File: tb/tb_tlb_l2_arbiter.sv
// Scoreboard bench for tlb_l2_arbiter with a behavioural L2 TLB cache model.
`timescale 1ns/1ps
module tb_tlb_l2_arbiter;
    import tlb_l2_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        code_req_do = 0, code_req_rw = 0;
    logic [31:0] code_req_linear = '0;
    logic        data_req_do = 0, data_req_rw = 0;
    logic [31:0] data_req_linear = '0;
    logic        code_done, code_hit, code_pwt, code_pcd, code_crw, code_csu;
    logic        data_done, data_hit, data_pwt, data_pcd, data_crw, data_csu;
    logic [31:0] code_physical, data_physical;
    logic        wr_do = 0, wr_pwt = 0, wr_pcd = 0, wr_crw = 0, wr_csu = 0, wr_dirty = 0;
    logic [31:0] wr_linear = '0, wr_physical = '0;
    logic        wr_done;
    logic        fl1_do = 0;
    logic [31:0] fl1_address = '0;
    logic        fl1_done, flall_do = 0, flall_done;
    logic        l2_translate_do, l2_rw, l2_write_do, l2_write_pwt, l2_write_pcd;
    logic        l2_write_crw, l2_write_csu, l2_flushsingle_do, l2_flushall_do;
    logic [31:0] l2_translate_linear, l2_write_linear, l2_write_physical;
    logic [31:0] l2_flushsingle_address;
    logic        l2_translate_valid, l2_translate_pwt, l2_translate_pcd;
    logic        l2_translate_crw, l2_translate_csu;
    logic [31:0] l2_translate_physical;

    tlb_l2_arbiter dut (
        .clk(clk), .rst(rst),
        .code_req_do(code_req_do), .code_req_linear(code_req_linear), .code_req_rw(code_req_rw),
        .code_done(code_done), .code_hit(code_hit), .code_physical(code_physical),
        .code_pwt(code_pwt), .code_pcd(code_pcd), .code_crw(code_crw), .code_csu(code_csu),
        .data_req_do(data_req_do), .data_req_linear(data_req_linear), .data_req_rw(data_req_rw),
        .data_done(data_done), .data_hit(data_hit), .data_physical(data_physical),
        .data_pwt(data_pwt), .data_pcd(data_pcd), .data_crw(data_crw), .data_csu(data_csu),
        .wr_do(wr_do), .wr_linear(wr_linear), .wr_physical(wr_physical), .wr_pwt(wr_pwt),
        .wr_pcd(wr_pcd), .wr_crw(wr_crw), .wr_csu(wr_csu), .wr_dirty(wr_dirty),
        .wr_done(wr_done),
        .fl1_do(fl1_do), .fl1_address(fl1_address), .fl1_done(fl1_done),
        .flall_do(flall_do), .flall_done(flall_done),
        .l2_translate_do(l2_translate_do), .l2_translate_linear(l2_translate_linear),
        .l2_rw(l2_rw), .l2_write_do(l2_write_do), .l2_write_linear(l2_write_linear),
        .l2_write_physical(l2_write_physical), .l2_write_pwt(l2_write_pwt),
        .l2_write_pcd(l2_write_pcd), .l2_write_crw(l2_write_crw), .l2_write_csu(l2_write_csu),
        .l2_flushsingle_do(l2_flushsingle_do), .l2_flushsingle_address(l2_flushsingle_address),
        .l2_flushall_do(l2_flushall_do),
        .l2_translate_valid(l2_translate_valid), .l2_translate_physical(l2_translate_physical),
        .l2_translate_pwt(l2_translate_pwt), .l2_translate_pcd(l2_translate_pcd),
        .l2_translate_crw(l2_translate_crw), .l2_translate_csu(l2_translate_csu)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Counters of L2 activity, sampled at the edge where the L2 acts on it.
    int l2_act = 0;
    int flall_pulses = 0;
    always @(posedge clk) begin
        if (l2_translate_do || l2_write_do || l2_flushsingle_do || l2_flushall_do)
            l2_act <= l2_act + 1;
        if (l2_flushall_do) flall_pulses <= flall_pulses + 1;
    end

    // L2 cache model: entry = {ppn[19:0], pwt, pcd, crw, csu, dirty}, one-cycle read.
    logic [24:0] tbl [int];
    int          mkey;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl.delete();
            l2_translate_valid    <= 1'b0;
            l2_translate_physical <= '0;
            {l2_translate_pwt, l2_translate_pcd, l2_translate_crw, l2_translate_csu} <= '0;
        end else begin
            if (l2_write_do && phys_accepted(l2_write_physical))
                tbl[int'(l2_write_linear[31:12])] = {l2_write_physical[31:12], l2_write_pwt,
                    l2_write_pcd, l2_write_crw, l2_write_csu, l2_rw};
            if (l2_flushsingle_do) tbl.delete(int'(l2_flushsingle_address[31:12]));
            if (l2_flushall_do) tbl.delete();
            if (l2_translate_do) begin
                mkey = int'(l2_translate_linear[31:12]);
                if (tbl.exists(mkey) && (!l2_rw || tbl[mkey][0])) begin
                    l2_translate_valid    <= 1'b1;
                    l2_translate_physical <= {tbl[mkey][24:5], l2_translate_linear[11:0]};
                    {l2_translate_pwt, l2_translate_pcd, l2_translate_crw, l2_translate_csu}
                        <= tbl[mkey][4:1];
                end else begin
                    l2_translate_valid    <= 1'b0;
                    l2_translate_physical <= l2_translate_linear;
                    {l2_translate_pwt, l2_translate_pcd, l2_translate_crw, l2_translate_csu}
                        <= '0;
                end
            end
        end
    end

    // Scoreboard: kind 0 code, 1 data, 2 wr, 3 fl1, 4 flall; cyc = required done cycle.
    typedef struct {
        int          kind;
        int          cyc;
        lookup_res_t res;
    } exp_t;
    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic lookup_res_t res_hit(logic [31:0] phys, logic [3:0] attr);
        return {1'b1, phys, attr};
    endfunction

    function automatic lookup_res_t res_miss(logic [31:0] lin);
        return {1'b0, lin, 4'b0000};
    endfunction

    task automatic expect_item(int kind, int lat, lookup_res_t r);
        expq.push_back('{kind: kind, cyc: cyc + lat, res: r});
    endtask

    task automatic pop_check(int kind, lookup_res_t act);
        exp_t e;
        if (expq.size() == 0) begin
            chk($sformatf("unexpected_done_kind%0d", kind), 1, 0);
        end else begin
            e = expq.pop_front();
            chk("done_kind", kind, e.kind);
            chk($sformatf("done_cycle_kind%0d", kind), cyc, e.cyc);
            if (kind < 2) chk($sformatf("result_kind%0d", kind), act, e.res);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (code_done) pop_check(0, {code_hit, code_physical, code_pwt, code_pcd,
                                             code_crw, code_csu});
                if (data_done) pop_check(1, {data_hit, data_physical, data_pwt, data_pcd,
                                             data_crw, data_csu});
                if (wr_done)    pop_check(2, '0);
                if (fl1_done)   pop_check(3, '0);
                if (flall_done) pop_check(4, '0);
            end
        end
    endtask

    function automatic logic done_of(int w);
        case (w)
            0:       return code_done;
            1:       return data_done;
            2:       return wr_done;
            3:       return fl1_done;
            default: return flall_done;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic wait_done(int which);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_of(which) && n < 400);
        if (!done_of(which)) chk($sformatf("timeout_kind%0d", which), 0, 1);
    endtask

    task automatic lookup(logic is_data, logic [31:0] a, logic rw);
        if (is_data) begin
            data_req_linear = a; data_req_rw = rw; data_req_do = 1'b1;
            wait_done(1);
            data_req_do = 1'b0;
        end else begin
            code_req_linear = a; code_req_rw = rw; code_req_do = 1'b1;
            wait_done(0);
            code_req_do = 1'b0;
        end
    endtask

    task automatic lookup_loop(logic is_data, int n, logic [31:0] a);
        for (int i = 0; i < n; i++) begin
            lookup(is_data, a, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic fill(logic [31:0] lin, logic [31:0] phys, logic [3:0] attr, logic dirty);
        wr_linear = lin; wr_physical = phys; {wr_pwt, wr_pcd, wr_crw, wr_csu} = attr;
        wr_dirty = dirty; wr_do = 1'b1;
        wait_done(2);
        wr_do = 1'b0;
    endtask

    task automatic flush1(logic [31:0] a);
        fl1_address = a; fl1_do = 1'b1;
        wait_done(3);
        fl1_do = 1'b0;
    endtask

    task automatic flushall();
        flall_do = 1'b1;
        wait_done(4);
        flall_do = 1'b0;
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_dones"}, {code_done, data_done, wr_done, fl1_done, flall_done}, 5'b0);
        chk({tag, "_hits"}, {code_hit, data_hit}, 2'b0);
        chk({tag, "_strobes"}, {l2_translate_do, l2_write_do, l2_flushsingle_do,
                                l2_flushall_do}, 4'b0);
        chk({tag, "_phys"}, {code_physical, data_physical}, 64'h0);
    endtask

    int base;
    int r;

    initial begin
        fork
            monitor();
        join_none

        // Reset state, then release with a code lookup already pending.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        r = cyc;
        code_req_linear = 32'h1234_5678; code_req_rw = 1'b0; code_req_do = 1'b1;
        expect_item(0, 261, res_miss(32'h1234_5678));
        base = l2_act;
        repeat (258) @(negedge clk);
        chk("quiet_wait_flush", l2_act - base, 0);
        wait_done(0);
        code_req_do = 1'b0;
        @(negedge clk);

        // Fill, hit, dirty-bit miss, and the 64 MB fill boundary.
        expect_item(2, 2, '0);
        fill(32'h0040_3000, 32'h0012_3000, 4'b1010, 1'b0);
        @(negedge clk);
        expect_item(1, 3, res_hit(32'h0012_3ABC, 4'b1010));
        lookup(1'b1, 32'h0040_3ABC, 1'b0);
        @(negedge clk);
        expect_item(1, 3, res_miss(32'h0040_3ABC));
        lookup(1'b1, 32'h0040_3ABC, 1'b1);
        @(negedge clk);
        expect_item(2, 2, '0);
        fill(32'h0050_0000, 32'h0400_0000, 4'b1111, 1'b0);
        @(negedge clk);
        expect_item(2, 2, '0);
        fill(32'h0060_0000, 32'h03FF_F000, 4'b0001, 1'b0);
        @(negedge clk);
        expect_item(1, 3, res_miss(32'h0050_0123));
        lookup(1'b1, 32'h0050_0123, 1'b0);
        @(negedge clk);
        expect_item(1, 3, res_hit(32'h03FF_F456, 4'b0001));
        lookup(1'b1, 32'h0060_0456, 1'b0);
        @(negedge clk);

        // Code and data contending for four lookups.
`ifdef TLB_L2_ARB_RR_EN
        expect_item(0, 3,  res_hit(32'h0012_3111, 4'b1010));
        expect_item(1, 6,  res_hit(32'h03FF_F222, 4'b0001));
        expect_item(0, 9,  res_hit(32'h0012_3111, 4'b1010));
        expect_item(1, 12, res_hit(32'h03FF_F222, 4'b0001));
`else
        expect_item(1, 3,  res_hit(32'h03FF_F222, 4'b0001));
        expect_item(0, 6,  res_hit(32'h0012_3111, 4'b1010));
        expect_item(1, 9,  res_hit(32'h03FF_F222, 4'b0001));
        expect_item(0, 12, res_hit(32'h0012_3111, 4'b1010));
`endif
        fork
            lookup_loop(1'b0, 2, 32'h0040_3111);
            lookup_loop(1'b1, 2, 32'h0060_0222);
        join
        @(negedge clk);

        // Flush-all and fill raised together: flush first, then the fill.
        base = flall_pulses;
        expect_item(4, 259, '0);
        expect_item(2, 261, '0);
        fork
            flushall();
            fill(32'h0070_0000, 32'h0001_0000, 4'b0100, 1'b1);
        join
        @(negedge clk);
        chk("flushall_pulses", flall_pulses - base, 1);
        expect_item(1, 3, res_miss(32'h0040_3ABC));
        lookup(1'b1, 32'h0040_3ABC, 1'b0);
        @(negedge clk);
        expect_item(1, 3, res_hit(32'h0001_0010, 4'b0100));
        lookup(1'b1, 32'h0070_0010, 1'b1);
        @(negedge clk);

        // Single-page invalidate.
        expect_item(2, 2, '0);
        fill(32'h0080_0000, 32'h0020_0000, 4'b0101, 1'b1);
        @(negedge clk);
        expect_item(1, 3, res_hit(32'h0020_0ABC, 4'b0101));
        lookup(1'b1, 32'h0080_0ABC, 1'b1);
        @(negedge clk);
        expect_item(3, 2, '0);
        flush1(32'h0080_0ABC);
        @(negedge clk);
        expect_item(0, 3, res_miss(32'h0080_0ABC));
        lookup(1'b0, 32'h0080_0ABC, 1'b0);
        @(negedge clk);

        // Reset during LK_CMP: no done, lookup re-served after the reset sweep.
        code_req_linear = 32'h0070_0044; code_req_rw = 1'b0; code_req_do = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midop_reset");
        rst = 1'b0;
        expect_item(0, 261, res_miss(32'h0070_0044));
        wait_done(0);
        code_req_do = 1'b0;
        repeat (4) @(negedge clk);

        chk("queue_empty", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
